// File: rtl/d_ereg_fwd.sv
// d_ereg_fwd: Y86-64 decode stage with operand forwarding and the E register.
//
// Build option: define D_FWD_EN for full E/M/W forwarding. With it undefined,
// operands come straight from the register file and d_hazard_o flags every
// pending write to a source register, not only load-use cases.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   D_*_i                    fields of the F/D pipeline register
//   d_srcA_o, d_srcB_o       register-file read IDs (combinational)
//   d_rvalA_i, d_rvalB_i     register-file read data
//   e_/M_/m_/W_ dst/val      in-flight results usable for forwarding
//   E_stall_i, E_bubble_i    E register control (bubble wins)
//   d_hazard_o               hazard flag to pipeline control (combinational)
//   E_*_o                    E pipeline register contents
module d_ereg_fwd #(
  parameter int unsigned W     = 64,
  parameter logic [3:0]  RNONE = 4'hf,
  parameter logic [3:0]  RRSP  = 4'h4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   D_stat_i,
  input  logic [3:0]   D_icode_i,
  input  logic [3:0]   D_ifun_i,
  input  logic [3:0]   D_rA_i,
  input  logic [3:0]   D_rB_i,
  input  logic [W-1:0] D_valC_i,
  input  logic [W-1:0] D_valP_i,
  output logic [3:0]   d_srcA_o,
  output logic [3:0]   d_srcB_o,
  input  logic [W-1:0] d_rvalA_i,
  input  logic [W-1:0] d_rvalB_i,
  input  logic [3:0]   e_dstE_i,
  input  logic [W-1:0] e_valE_i,
  input  logic [3:0]   M_dstE_i,
  input  logic [W-1:0] M_valE_i,
  input  logic [3:0]   M_dstM_i,
  input  logic [W-1:0] m_valM_i,
  input  logic [3:0]   W_dstE_i,
  input  logic [W-1:0] W_valE_i,
  input  logic [3:0]   W_dstM_i,
  input  logic [W-1:0] W_valM_i,
  input  logic         E_stall_i,
  input  logic         E_bubble_i,
  output logic         d_hazard_o,
  output logic [3:0]   E_stat_o,
  output logic [3:0]   E_icode_o,
  output logic [3:0]   E_ifun_o,
  output logic [3:0]   E_dstE_o,
  output logic [3:0]   E_dstM_o,
  output logic [3:0]   E_srcA_o,
  output logic [3:0]   E_srcB_o,
  output logic [W-1:0] E_valC_o,
  output logic [W-1:0] E_valA_o,
  output logic [W-1:0] E_valB_o
);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0, I_NOP    = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ    = 4'h6, I_JXX    = 4'h7,
    I_CALL   = 4'h8, I_RET    = 4'h9, I_PUSHQ  = 4'hA, I_POPQ   = 4'hB
  } icode_t;

  localparam logic [3:0] STAT_AOK = 4'h1;

  logic [3:0]   srcA, srcB, dstE, dstM;
  logic [W-1:0] valA, valB;
  logic         loadUse;

  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (D_icode_i)
      I_RRMOVQ: begin srcA = D_rA_i; dstE = D_rB_i; end
      I_IRMOVQ: dstE = D_rB_i;
      I_RMMOVQ: begin srcA = D_rA_i; srcB = D_rB_i; end
      I_MRMOVQ: begin srcB = D_rB_i; dstM = D_rA_i; end
      I_OPQ:    begin srcA = D_rA_i; srcB = D_rB_i; dstE = D_rB_i; end
      I_PUSHQ:  begin srcA = D_rA_i; srcB = RRSP; dstE = RRSP; end
      I_POPQ:   begin srcA = RRSP; srcB = RRSP; dstE = RRSP; dstM = D_rA_i; end
      I_CALL:   begin srcB = RRSP; dstE = RRSP; end
      I_RET:    begin srcA = RRSP; srcB = RRSP; dstE = RRSP; end
      default: ;
    endcase
  end

  assign d_srcA_o = srcA;
  assign d_srcB_o = srcB;

  // A load in E can only be forwarded once it reaches M, so any consumer of
  // its destination must be held for a cycle.
  assign loadUse = (E_icode_o == I_MRMOVQ || E_icode_o == I_POPQ) &&
                   (E_dstM_o != RNONE) &&
                   (E_dstM_o == srcA || E_dstM_o == srcB);

`ifdef D_FWD_EN
  // Youngest producer first; m_valM outranks M_valE so popq's loaded value
  // wins over its own %rsp update when both target the same register.
  always_comb begin
    valA = d_rvalA_i;
    if (D_icode_i == I_CALL || D_icode_i == I_JXX) valA = D_valP_i;
    else if (srcA != RNONE) begin
      if      (srcA == e_dstE_i) valA = e_valE_i;
      else if (srcA == M_dstM_i) valA = m_valM_i;
      else if (srcA == M_dstE_i) valA = M_valE_i;
      else if (srcA == W_dstM_i) valA = W_valM_i;
      else if (srcA == W_dstE_i) valA = W_valE_i;
    end
  end

  always_comb begin
    valB = d_rvalB_i;
    if (srcB != RNONE) begin
      if      (srcB == e_dstE_i) valB = e_valE_i;
      else if (srcB == M_dstM_i) valB = m_valM_i;
      else if (srcB == M_dstE_i) valB = M_valE_i;
      else if (srcB == W_dstM_i) valB = W_valM_i;
      else if (srcB == W_dstE_i) valB = W_valE_i;
    end
  end

  assign d_hazard_o = loadUse;
`else
  logic pendA, pendB;
  logic unusedFwdVals;

  assign valA = (D_icode_i == I_CALL || D_icode_i == I_JXX) ? D_valP_i : d_rvalA_i;
  assign valB = d_rvalB_i;

  assign pendA = (srcA != RNONE) &&
                 (srcA == e_dstE_i || srcA == M_dstE_i || srcA == M_dstM_i ||
                  srcA == W_dstE_i || srcA == W_dstM_i);
  assign pendB = (srcB != RNONE) &&
                 (srcB == e_dstE_i || srcB == M_dstE_i || srcB == M_dstM_i ||
                  srcB == W_dstE_i || srcB == W_dstM_i);

  assign d_hazard_o = loadUse || pendA || pendB;

  assign unusedFwdVals = ^{e_valE_i, M_valE_i, m_valM_i, W_valE_i, W_valM_i};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst || E_bubble_i) begin
      E_stat_o  <= STAT_AOK;
      E_icode_o <= I_NOP;
      E_ifun_o  <= '0;
      E_dstE_o  <= RNONE;
      E_dstM_o  <= RNONE;
      E_srcA_o  <= RNONE;
      E_srcB_o  <= RNONE;
      E_valC_o  <= '0;
      E_valA_o  <= '0;
      E_valB_o  <= '0;
    end else if (!E_stall_i) begin
      E_stat_o  <= D_stat_i;
      E_icode_o <= D_icode_i;
      E_ifun_o  <= D_ifun_i;
      E_dstE_o  <= dstE;
      E_dstM_o  <= dstM;
      E_srcA_o  <= srcA;
      E_srcB_o  <= srcB;
      E_valC_o  <= D_valC_i;
      E_valA_o  <= valA;
      E_valB_o  <= valB;
    end
  end

endmodule

// File: tb/tb_d_ereg_fwd.sv
`timescale 1ns/1ps
module tb_d_ereg_fwd;
  localparam int W = 64;
  localparam logic [3:0] RN = 4'hf;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] D_stat_i, D_icode_i, D_ifun_i, D_rA_i, D_rB_i;
  logic [W-1:0] D_valC_i, D_valP_i, d_rvalA_i, d_rvalB_i;
  logic [3:0] d_srcA_o, d_srcB_o;
  logic [3:0] e_dstE_i, M_dstE_i, M_dstM_i, W_dstE_i, W_dstM_i;
  logic [W-1:0] e_valE_i, M_valE_i, m_valM_i, W_valE_i, W_valM_i;
  logic E_stall_i, E_bubble_i, d_hazard_o;
  logic [3:0] E_stat_o, E_icode_o, E_ifun_o, E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o;
  logic [W-1:0] E_valC_o, E_valA_o, E_valB_o;

  always #5 clk = ~clk;

  d_ereg_fwd #(.W(W), .RNONE(4'hf), .RRSP(4'h4)) dut (
    .clk(clk), .rst(rst),
    .D_stat_i(D_stat_i), .D_icode_i(D_icode_i), .D_ifun_i(D_ifun_i),
    .D_rA_i(D_rA_i), .D_rB_i(D_rB_i), .D_valC_i(D_valC_i), .D_valP_i(D_valP_i),
    .d_srcA_o(d_srcA_o), .d_srcB_o(d_srcB_o),
    .d_rvalA_i(d_rvalA_i), .d_rvalB_i(d_rvalB_i),
    .e_dstE_i(e_dstE_i), .e_valE_i(e_valE_i),
    .M_dstE_i(M_dstE_i), .M_valE_i(M_valE_i),
    .M_dstM_i(M_dstM_i), .m_valM_i(m_valM_i),
    .W_dstE_i(W_dstE_i), .W_valE_i(W_valE_i),
    .W_dstM_i(W_dstM_i), .W_valM_i(W_valM_i),
    .E_stall_i(E_stall_i), .E_bubble_i(E_bubble_i), .d_hazard_o(d_hazard_o),
    .E_stat_o(E_stat_o), .E_icode_o(E_icode_o), .E_ifun_o(E_ifun_o),
    .E_dstE_o(E_dstE_o), .E_dstM_o(E_dstM_o), .E_srcA_o(E_srcA_o), .E_srcB_o(E_srcB_o),
    .E_valC_o(E_valC_o), .E_valA_o(E_valA_o), .E_valB_o(E_valB_o)
  );

  typedef struct {
    logic [3:0] stat, icode, ifun, dstE, dstM, srcA, srcB;
    logic [W-1:0] valC, valA, valB;
  } eReg_t;

  typedef struct {
    eReg_t e;
    logic [3:0] srcA, srcB;
    logic hazard;
  } snap_t;

  typedef struct {
    logic rst, stall, bubble;
    logic [3:0] stat, icode, ifun, rA, rB, eDstE, mDstE, mDstM, wDstE, wDstM;
    logic [W-1:0] valC, valP, rvalA, rvalB, eValE, mValE, mValM, wValE, wValM;
  } stim_t;

  snap_t q[$];
  eReg_t mdl;
  int total = 0;
  int bad = 0;

  // Instruction-class membership as bit masks indexed by icode.
  localparam logic [15:0] SRCA_REG = 16'h0454, SRCA_RSP = 16'h0A00;
  localparam logic [15:0] SRCB_REG = 16'h0070, SRCB_RSP = 16'h0F00;
  localparam logic [15:0] DSTE_REG = 16'h004C, DSTE_RSP = 16'h0F00;
  localparam logic [15:0] DSTM_REG = 16'h0820, DSTM_RSP = 16'h0000;

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic eReg_t nopReg();
    eReg_t r;
    r.stat = 4'h1; r.icode = 4'h1; r.ifun = 4'h0;
    r.dstE = RN; r.dstM = RN; r.srcA = RN; r.srcB = RN;
    r.valC = '0; r.valA = '0; r.valB = '0;
    return r;
  endfunction

  function automatic logic [3:0] pick(input logic [3:0] ic, input logic [3:0] r,
                                      input logic [15:0] regSet, input logic [15:0] rspSet);
    if (regSet[ic]) return r;
    if (rspSet[ic]) return 4'h4;
    return RN;
  endfunction

  function automatic logic [W-1:0] fwd(input logic [3:0] src, input logic [W-1:0] raw,
                                       input stim_t s);
    logic [3:0] d[5];
    logic [W-1:0] v[5];
    d = '{s.eDstE, s.mDstM, s.mDstE, s.wDstM, s.wDstE};
    v = '{s.eValE, s.mValM, s.mValE, s.wValM, s.wValE};
    if (src == RN) return raw;
    for (int i = 0; i < 5; i++) if (d[i] == src) return v[i];
    return raw;
  endfunction

  function automatic logic pending(input logic [3:0] src, input stim_t s);
    logic [3:0] d[5];
    d = '{s.eDstE, s.mDstE, s.mDstM, s.wDstE, s.wDstM};
    if (src == RN) return 1'b0;
    for (int i = 0; i < 5; i++) if (d[i] == src) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one D/forwarding input set, record the expected snapshot for this
  // cycle, and advance the model to what E should hold after the next edge.
  task automatic apply(input stim_t s);
    snap_t sn;
    eReg_t nx;
    logic [3:0] sA, sB;
    logic [W-1:0] vA, vB;
    logic hz;
    D_stat_i = s.stat; D_icode_i = s.icode; D_ifun_i = s.ifun;
    D_rA_i = s.rA; D_rB_i = s.rB; D_valC_i = s.valC; D_valP_i = s.valP;
    d_rvalA_i = s.rvalA; d_rvalB_i = s.rvalB;
    e_dstE_i = s.eDstE; e_valE_i = s.eValE;
    M_dstE_i = s.mDstE; M_valE_i = s.mValE;
    M_dstM_i = s.mDstM; m_valM_i = s.mValM;
    W_dstE_i = s.wDstE; W_valE_i = s.wValE;
    W_dstM_i = s.wDstM; W_valM_i = s.wValM;
    E_stall_i = s.stall; E_bubble_i = s.bubble;
    rst = s.rst;
    if (s.rst) mdl = nopReg();
    sA = pick(s.icode, s.rA, SRCA_REG, SRCA_RSP);
    sB = pick(s.icode, s.rB, SRCB_REG, SRCB_RSP);
    hz = (mdl.icode == 4'h5 || mdl.icode == 4'hB) && mdl.dstM != RN &&
         (mdl.dstM == sA || mdl.dstM == sB);
`ifdef D_FWD_EN
    vA = (s.icode == 4'h8 || s.icode == 4'h7) ? s.valP : fwd(sA, s.rvalA, s);
    vB = fwd(sB, s.rvalB, s);
`else
    vA = (s.icode == 4'h8 || s.icode == 4'h7) ? s.valP : s.rvalA;
    vB = s.rvalB;
    hz = hz || pending(sA, s) || pending(sB, s);
`endif
    sn.e = mdl; sn.srcA = sA; sn.srcB = sB; sn.hazard = hz;
    q.push_back(sn);
    if (s.rst || s.bubble) nx = nopReg();
    else if (s.stall) nx = mdl;
    else begin
      nx.stat = s.stat; nx.icode = s.icode; nx.ifun = s.ifun;
      nx.dstE = pick(s.icode, s.rB, DSTE_REG, DSTE_RSP);
      nx.dstM = pick(s.icode, s.rA, DSTM_REG, DSTM_RSP);
      nx.srcA = sA; nx.srcB = sB;
      nx.valC = s.valC; nx.valA = vA; nx.valB = vB;
    end
    mdl = nx;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.stall = 0; s.bubble = 0;
    s.stat = 4'h1; s.icode = 4'h1; s.ifun = 0; s.rA = RN; s.rB = RN;
    s.eDstE = RN; s.mDstE = RN; s.mDstM = RN; s.wDstE = RN; s.wDstM = RN;
    s.valC = '0; s.valP = '0; s.rvalA = '0; s.rvalB = '0;
    s.eValE = '0; s.mValE = '0; s.mValM = '0; s.wValE = '0; s.wValM = '0;
    return s;
  endfunction

  function automatic logic [3:0] rndReg();
    int unsigned r;
    r = $urandom_range(0, 6);
    return (r == 6) ? RN : 4'(r);
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst = 0;
    s.stall = ($urandom_range(0, 4) == 0);
    s.bubble = ($urandom_range(0, 9) == 0);
    s.stat = 4'($urandom_range(1, 4)); s.icode = 4'($urandom_range(0, 15));
    s.ifun = 4'($urandom_range(0, 15));
    s.rA = rndReg(); s.rB = rndReg();
    s.eDstE = rndReg(); s.mDstE = rndReg(); s.mDstM = rndReg();
    s.wDstE = rndReg(); s.wDstM = rndReg();
    s.valC = rnd64(); s.valP = rnd64(); s.rvalA = rnd64(); s.rvalB = rnd64();
    s.eValE = rnd64(); s.mValE = rnd64(); s.mValM = rnd64();
    s.wValE = rnd64(); s.wValM = rnd64();
    return s;
  endfunction

  // Monitor: every cycle with a recorded expectation is checked mid-cycle.
  initial begin
    snap_t sn;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        sn = q.pop_front();
        cmp("srcA", d_srcA_o, sn.srcA);
        cmp("srcB", d_srcB_o, sn.srcB);
        cmp("hazard", d_hazard_o, sn.hazard);
        cmp("E_stat", E_stat_o, sn.e.stat);
        cmp("E_icode", E_icode_o, sn.e.icode);
        cmp("E_ifun", E_ifun_o, sn.e.ifun);
        cmp("E_dstE", E_dstE_o, sn.e.dstE);
        cmp("E_dstM", E_dstM_o, sn.e.dstM);
        cmp("E_srcA", E_srcA_o, sn.e.srcA);
        cmp("E_srcB", E_srcB_o, sn.e.srcB);
        cmp("E_valC", E_valC_o, sn.e.valC);
        cmp("E_valA", E_valA_o, sn.e.valA);
        cmp("E_valB", E_valB_o, sn.e.valB);
      end
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1;
    apply(s);
    q.delete();
    tick();
    s.rst = 1; apply(s); tick();
    s.rst = 0; apply(s); tick();

    // Forwarding priority: execute-stage result beats memory-stage ALU result.
    s = idle(); s.icode = 4'h6; s.rA = 4'h0; s.rB = 4'h3;
    s.eDstE = 4'h0; s.eValE = 13; s.mDstE = 4'h0; s.mValE = 99;
    s.rvalA = 5; s.rvalB = 7;
    apply(s); tick();
`ifdef D_FWD_EN
    cmp("prio_valA", E_valA_o, 13);
`else
    cmp("prio_valA", E_valA_o, 5);
`endif
    cmp("prio_valB", E_valB_o, 7);
    cmp("prio_dstE", E_dstE_o, 3);

    // Writeback-stage forwarding.
    s = idle(); s.icode = 4'h2; s.rA = 4'h0; s.rB = 4'h1;
    s.wDstE = 4'h0; s.wValE = 13; s.rvalA = 5;
    apply(s); #1;
`ifdef D_FWD_EN
    cmp("wb_hazard", d_hazard_o, 0);
`else
    cmp("wb_hazard", d_hazard_o, 1);
`endif
    tick();
`ifdef D_FWD_EN
    cmp("wb_valA", E_valA_o, 13);
`else
    cmp("wb_valA", E_valA_o, 5);
`endif

    // call: valA is the return address, valB is %rsp.
    s = idle(); s.icode = 4'h8; s.valP = 40; s.mDstE = 4'h4; s.mValE = 88; s.rvalB = 100;
    apply(s); tick();
    cmp("call_valA", E_valA_o, 40);
`ifdef D_FWD_EN
    cmp("call_valB", E_valB_o, 88);
`else
    cmp("call_valB", E_valB_o, 100);
`endif
    cmp("call_dstE", E_dstE_o, 4);

    // Load-use: mrmovq into %rdx sits in E while opq decodes.
    s = idle(); s.icode = 4'h5; s.rA = 4'h2; s.rB = 4'h1;
    apply(s); tick();
    s = idle(); s.icode = 4'h6; s.rA = 4'h2; s.rB = 4'h6; s.stall = 1;
    apply(s); #1;
    cmp("lu_hit", d_hazard_o, 1);
    tick();
    s = idle(); s.icode = 4'h6; s.rA = 4'h3; s.rB = 4'h5;
    apply(s); #1;
    cmp("lu_miss", d_hazard_o, 0);
    tick();

    // Stall holds E for two cycles, then stall+bubble inserts a nop.
    s = idle(); s.icode = 4'h3; s.rB = 4'h7; s.valC = 55;
    apply(s); tick();
    for (int i = 0; i < 2; i++) begin
      s = rnd(); s.stall = 1; s.bubble = 0;
      apply(s); tick();
      cmp("stall_dstE", E_dstE_o, 7);
      cmp("stall_valC", E_valC_o, 55);
    end
    s = rnd(); s.stall = 1; s.bubble = 1;
    apply(s); tick();
    cmp("sb_icode", E_icode_o, 1);
    cmp("sb_dstE", E_dstE_o, RN);
    cmp("sb_valA", E_valA_o, 0);

    repeat (300) begin
      s = rnd();
      apply(s); tick();
    end

    // Asynchronous reset mid-cycle with arbitrary E contents.
    s = rnd(); s.stall = 0; s.bubble = 0; s.icode = 4'h6; s.rA = 4'h1; s.rB = 4'h2;
    apply(s); tick();
    s = rnd(); s.rst = 1;
    apply(s); #1;
    cmp("rst_icode", E_icode_o, 1);
    cmp("rst_stat", E_stat_o, 1);
    cmp("rst_dstE", E_dstE_o, RN);
    cmp("rst_dstM", E_dstM_o, RN);
    cmp("rst_srcA", E_srcA_o, RN);
    cmp("rst_srcB", E_srcB_o, RN);
    cmp("rst_valA", E_valA_o, 0);
    tick();

    repeat (100) begin
      s = rnd();
      apply(s); tick();
    end

    @(negedge clk);
    @(negedge clk);
    cmp("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/d_ereg_fwd.md
Name: d_ereg_fwd

Overview:
- Decode stage of the Y86-64 pipeline.
- Drives source-register IDs into the register file and takes its raw read data back.
- Resolves data forwarding from the E/M/W stages and flags load-use hazards to pipeline control.
- Latches the decoded instruction into the E pipeline register with stall/bubble control.
- Sits between the F/D register and the execute stage; the register file is its direct neighbour.

Parameters:
- W, 64, data path width.
- RNONE, 4'hf, "no register" ID.
- RRSP, 4'h4, stack pointer ID.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- D_stat_i  in  4  status from D register (AOK=1, HLT=2, ADR=3, INS=4).
- D_icode_i, D_ifun_i  in  4 each  decoded opcode and function.
- D_rA_i, D_rB_i  in  4 each  register specifiers.
- D_valC_i, D_valP_i  in  W each  constant and next PC.
- d_srcA_o, d_srcB_o  out  4 each  register-file read IDs (combinational).
- d_rvalA_i, d_rvalB_i  in  W each  register-file read data.
- e_dstE_i / e_valE_i  in  4 / W  execute-stage result.
- M_dstE_i / M_valE_i  in  4 / W  memory-stage ALU result.
- M_dstM_i / m_valM_i  in  4 / W  memory-stage load result.
- W_dstE_i / W_valE_i, W_dstM_i / W_valM_i  in  4 / W  writeback results.
- E_stall_i, E_bubble_i  in  1 each  pipeline control.
- d_hazard_o  out  1  load-use hazard (combinational).
- E_stat_o, E_icode_o, E_ifun_o, E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o  out  4 each  E register fields.
- E_valC_o, E_valA_o, E_valB_o  out  W each  E register data.

Behaviour:
- Source-ID decode:
  - srcA = rA for rrmovq(2), rmmovq(4), opq(6), pushq(A); RSP for popq(B), ret(9); else RNONE.
  - srcB = rB for rmmovq, mrmovq(5), opq; RSP for pushq, popq, call(8), ret; else RNONE.
- Destination decode:
  - dstE = rB for rrmovq, irmovq(3), opq; RSP for pushq, popq, call, ret; else RNONE.
  - dstM = rA for mrmovq, popq; else RNONE.
- valA selection, first match wins:
  - icode call or jxx(7) -> D_valP_i.
  - then srcA == e_dstE -> e_valE; == M_dstM -> m_valM; == M_dstE -> M_valE; == W_dstM -> W_valM; == W_dstE -> W_valE.
  - otherwise d_rvalA_i.
- valB selection: same priority chain, without the valP term.
- An RNONE source never matches any forwarding source.
- Hazard: d_hazard_o = 1 when E_icode_o is mrmovq or popq, E_dstM_o != RNONE, and E_dstM_o equals d_srcA_o or d_srcB_o.
- The block only flags the hazard; control owns the stall/bubble decision.
- E register update, rising edge:
  - E_bubble_i = 1 -> load a nop: icode=1, ifun=0, stat=AOK, all IDs=RNONE, all data=0.
  - else E_stall_i = 1 -> hold all fields.
  - else -> load decoded fields plus selected valA/valB.
  - Bubble has priority over stall.
- Reset:
  - rst high clears the E register to the nop bubble state immediately, independent of clk, including mid-operation.
  - While rst is high, stall and bubble are ignored.
- Latency: one cycle from D inputs to E outputs. Forward and hazard paths are same-cycle combinational.
- Data passes unmodified; no arithmetic. All widths are exact.

Optional Feature:
- Macro: D_FWD_EN.
- Defined: full forwarding as above. d_hazard_o covers load-use only.
- Undefined:
  - valA = valP for call/jxx, otherwise d_rvalA_i; valB = d_rvalB_i.
  - d_hazard_o asserts on any match of a non-RNONE srcA/srcB against e_dstE, M_dstE, M_dstM, W_dstE or W_dstM.
  - d_hazard_o also keeps the load-use term.

Test Plan:
- Reset: assert rst mid-run with arbitrary E contents -> E_icode_o=1, E_dstE_o=E_dstM_o=E_srcA_o=E_srcB_o=f, E_valA_o=0, E_stat_o=1 before the next edge.
- Priority: D opq rA=0 rB=3, e_dstE=0/e_valE=13, M_dstE=0/M_valE=99, d_rvalA=5, d_rvalB=7 -> next edge E_valA_o=13, E_valB_o=7, E_dstE_o=3.
- Writeback forwarding: D rrmovq rA=0, only W_dstE=0/W_valE=13 -> E_valA_o=13. Same test with D_FWD_EN undefined -> E_valA_o=d_rvalA_i and d_hazard_o=1.
- Call: D call valP=40, rA=f, M_dstE=4/M_valE=88, d_rvalB=100 -> E_valA_o=40, E_valB_o=88, E_dstE_o=4.
- Load-use: E holds mrmovq dstM=2; D opq rA=2 -> d_hazard_o=1. Same case with D rA=3, rB=5 -> d_hazard_o=0.
- Control: E_stall=1 for 2 cycles -> E fields unchanged. E_stall=1 and E_bubble=1 together -> nop loaded.
